fp_match_engine: RTL

- Comparison responder for the fingerprint signal path.
- Accepts a compare request on fp_start from the main key/RAM state controller.
- Reads the probe image and one or two enrolled templates from the fingerprint RAMs, word by word, and accumulates a Hamming distance.
- Returns a match verdict on fp_state, plus busy/done handshakes back to the controller.

---
 rtl/fp_pkg.sv | 23 ++
 rtl/fp_popcount.sv | 18 +
 rtl/fp_match_engine.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared encodings, FSM states and default sizing for the fingerprint match engine.
package fp_pkg;

   typedef enum logic [1:0] {
      FP_CMD_NONE = 2'b00,
      FP_CMD_T0   = 2'b01,
      FP_CMD_T1   = 2'b10,
      FP_CMD_BOTH = 2'b11
   } fp_cmd_e;

   typedef enum logic [2:0] {
      IDLE,
      RUN,
      DRAIN,
      DECIDE,
      DONE
   } fp_fsm_e;

   localparam int FP_DATA_W       = 16;
   localparam int FP_NUM_WORDS    = 2400;
   localparam int FP_MATCH_THRESH = 512;

endpackage

// File: rtl/fp_popcount.sv
// Combinational population count of one RAM word; the parent registers the result.
module fp_popcount #(
   parameter int DATA_W = 16
) (
   input  logic [DATA_W-1:0]          din,
   output logic [$clog2(DATA_W+1)-1:0] cnt
);

   localparam int CNT_W = $clog2(DATA_W+1);

   always_comb begin
      cnt = '0;
      for (int i = 0; i < DATA_W; i++) begin
         cnt = cnt + CNT_W'(din[i]);
      end
   end

endmodule

// File: rtl/fp_match_engine.sv
// Hamming-distance compare of a probe image against one or both enrolled templates.
// Optional FP_EARLY_EXIT_EN: abort a pass as soon as the running distance exceeds the threshold.
module fp_match_engine
   import fp_pkg::*;
#(
   parameter int DATA_W       = FP_DATA_W,
   parameter int NUM_WORDS    = FP_NUM_WORDS,
   parameter int ADDR_W       = 12,
   parameter int DIST_W       = 16,
   parameter int MATCH_THRESH = FP_MATCH_THRESH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        fp_start,
   output logic              fp_state,
   output logic              fp_busy,
   output logic              fp_done,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              rd_en,
   output logic              tpl_sel,
   input  logic [DATA_W-1:0] probe_rdata,
   input  logic [DATA_W-1:0] tpl_rdata,
   output logic [DIST_W-1:0] dist0,
   output logic [DIST_W-1:0] dist1
);

   localparam int PC_W = $clog2(DATA_W+1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS-1);
   localparam logic [DIST_W-1:0] THRESH    = DIST_W'(MATCH_THRESH);

   fp_fsm_e            state_q, state_d;
   logic [1:0]         mode_q, mode_d;
   logic [1:0]         prev_start_q;
   logic               fp_state_q, fp_state_d;
   logic               fp_busy_q, fp_busy_d;
   logic               fp_done_q, fp_done_d;
   logic               rd_en_q, rd_en_d;
   logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
   logic               tpl_sel_q, tpl_sel_d;
   logic [DIST_W-1:0]  dist0_q, dist0_d;
   logic [DIST_W-1:0]  dist1_q, dist1_d;
   logic [DIST_W-1:0]  acc_q, acc_d;
   logic [1:0]         drain_cnt_q, drain_cnt_d;
   logic               match0_q, match0_d;
   logic               verdict_q, verdict_d;

   // Three-stage datapath: XOR, popcount, accumulate; dvld marks RAM data arriving.
   logic               dvld_q, s1_vld_q, s2_vld_q;
   logic [DATA_W-1:0]  s1_x_q, s1_x_d;
   logic [PC_W-1:0]    s2_pc_q, s2_pc_d;
   logic [PC_W-1:0]    pc_comb;
   logic               pass_match;

   fp_popcount #(.DATA_W(DATA_W)) u_popcount (
      .din (s1_x_q),
      .cnt (pc_comb)
   );

   assign s1_x_d     = probe_rdata ^ tpl_rdata;
   assign s2_pc_d    = pc_comb;
   assign pass_match = (acc_q <= THRESH);

   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      fp_state_d  = fp_state_q;
      fp_busy_d   = fp_busy_q;
      fp_done_d   = 1'b0;
      rd_en_d     = 1'b0;
      rd_addr_d   = rd_addr_q;
      tpl_sel_d   = tpl_sel_q;
      dist0_d     = dist0_q;
      dist1_d     = dist1_q;
      acc_d       = s2_vld_q ? acc_q + DIST_W'(s2_pc_q) : acc_q;
      drain_cnt_d = drain_cnt_q;
      match0_d    = match0_q;
      verdict_d   = verdict_q;

      case (state_q)
         IDLE: begin
            rd_addr_d = '0;
            if (fp_start != FP_CMD_NONE && prev_start_q == FP_CMD_NONE) begin
               state_d    = RUN;
               mode_d     = fp_start;
               fp_busy_d  = 1'b1;
               fp_state_d = 1'b0;
               dist0_d    = '0;
               dist1_d    = '0;
               acc_d      = '0;
               rd_en_d    = 1'b1;
               tpl_sel_d  = (fp_start == FP_CMD_T1);
            end
         end
         RUN: begin
            rd_en_d   = 1'b1;
            rd_addr_d = rd_addr_q + 1'b1;
            if (rd_addr_q == LAST_ADDR) begin
               state_d     = DRAIN;
               rd_en_d     = 1'b0;
               rd_addr_d   = rd_addr_q;
               drain_cnt_d = '0;
            end
`ifdef FP_EARLY_EXIT_EN
            if (acc_q > THRESH) begin
               state_d     = DRAIN;
               rd_en_d     = 1'b0;
               rd_addr_d   = rd_addr_q;
               drain_cnt_d = '0;
            end
`endif
         end
         DRAIN: begin
            drain_cnt_d = drain_cnt_q + 1'b1;
            if (drain_cnt_q == 2'd2) begin
               state_d = DECIDE;
            end
         end
         DECIDE: begin
            if (tpl_sel_q) begin
               dist1_d = acc_q;
            end else begin
               dist0_d = acc_q;
            end
            if (mode_q == FP_CMD_BOTH && !tpl_sel_q) begin
               match0_d  = pass_match;
               acc_d     = '0;
               tpl_sel_d = 1'b1;
               rd_en_d   = 1'b1;
               rd_addr_d = '0;
               state_d   = RUN;
            end else begin
               verdict_d = (mode_q == FP_CMD_BOTH) ? (match0_q | pass_match) : pass_match;
               state_d   = DONE;
            end
         end
         DONE: begin
            fp_done_d  = 1'b1;
            fp_busy_d  = 1'b0;
            fp_state_d = verdict_q;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         mode_q       <= '0;
         prev_start_q <= '0;
         fp_state_q   <= 1'b0;
         fp_busy_q    <= 1'b0;
         fp_done_q    <= 1'b0;
         rd_en_q      <= 1'b0;
         rd_addr_q    <= '0;
         tpl_sel_q    <= 1'b0;
         dist0_q      <= '0;
         dist1_q      <= '0;
         acc_q        <= '0;
         drain_cnt_q  <= '0;
         match0_q     <= 1'b0;
         verdict_q    <= 1'b0;
         dvld_q       <= 1'b0;
         s1_vld_q     <= 1'b0;
         s2_vld_q     <= 1'b0;
         s1_x_q       <= '0;
         s2_pc_q      <= '0;
      end else begin
         state_q      <= state_d;
         mode_q       <= mode_d;
         prev_start_q <= fp_start;
         fp_state_q   <= fp_state_d;
         fp_busy_q    <= fp_busy_d;
         fp_done_q    <= fp_done_d;
         rd_en_q      <= rd_en_d;
         rd_addr_q    <= rd_addr_d;
         tpl_sel_q    <= tpl_sel_d;
         dist0_q      <= dist0_d;
         dist1_q      <= dist1_d;
         acc_q        <= acc_d;
         drain_cnt_q  <= drain_cnt_d;
         match0_q     <= match0_d;
         verdict_q    <= verdict_d;
         dvld_q       <= rd_en_q;
         s1_vld_q     <= dvld_q;
         s2_vld_q     <= s1_vld_q;
         s1_x_q       <= s1_x_d;
         s2_pc_q      <= s2_pc_d;
      end
   end

   assign fp_state = fp_state_q;
   assign fp_busy  = fp_busy_q;
   assign fp_done  = fp_done_q;
   assign rd_en    = rd_en_q;
   assign rd_addr  = rd_addr_q;
   assign tpl_sel  = tpl_sel_q;
   assign dist0    = dist0_q;
   assign dist1    = dist1_q;

endmodule
